// File: rtl/wave_ram_loader.sv
// rtl/wave_ram_loader.sv - DDS waveform table with load port and registered read; WAVE_RAM_OUT_REG_EN adds an output register stage
module wave_ram_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  phase_ena,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_valid,
    output logic                  loaded
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic                    loaded_q, loaded_d;
    logic                    wr_en;
    logic                    rd_en;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    rd_valid_q;

    // Control state: FSM, write pointer and load-complete flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            loaded_q <= loaded_d;
        end
    end

    // Next-state logic; a restart in LOAD discards the beat presented with it
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        loaded_d = loaded_q;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                    loaded_d = 1'b0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    wr_ptr_d = '0;
                end else if (wr_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == '1) begin
                        state_d  = RUN;
                        loaded_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                    loaded_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wr_ready  = (state_q == LOAD);
    assign phase_ena = (state_q == RUN);
    assign loaded    = loaded_q;

    // Table storage; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Reads in the load_start cycle are flagged invalid so no stale sample follows a reload request
    assign rd_en = (state_q == RUN) && !load_start;

    // Registered read; data holds while no valid read is issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= mem_q[read_addr];
            end
        end
    end

`ifdef WAVE_RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;

    // Extra output stage toward the DAC; holds data across invalid cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rd_valid_q;
            if (rd_valid_q) begin
                out_data_q <= rd_data_q;
            end
        end
    end

    assign sample_out   = out_data_q;
    assign sample_valid = out_valid_q;
`else
    assign sample_out   = rd_data_q;
    assign sample_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_wave_ram_loader.sv
// tb/tb_wave_ram_loader.sv - scoreboard bench for wave_ram_loader with ADDR_WIDTH=4, DATA_WIDTH=8
module tb_wave_ram_loader;
`ifdef WAVE_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [7:0] data;
        int         due;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] read_addr;
    logic       phase_ena;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic       loaded;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic       exp_run = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] exp_mem [16];
    sb_t        sb [$];

    wave_ram_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .read_addr    (read_addr),
        .phase_ena    (phase_ena),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .loaded       (loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every falling edge the sample must match the scoreboard exactly
    always @(negedge clk) begin
        sb_t e;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("sample_valid_hi", 32'(sample_valid), 32'd1);
            chk("sample_out", 32'(sample_out), 32'(e.data));
            last_data = e.data;
        end else begin
            chk("sample_valid_lo", 32'(sample_valid), 32'd0);
            chk("sample_hold", 32'(sample_out), 32'(last_data));
        end
    end

    // One clock of stimulus driven at a falling edge; reads in RUN are scoreboarded
    task automatic step(input logic ls, input logic wv, input logic [7:0] wd, input logic [3:0] ra);
        sb_t e;
        load_start = ls;
        wr_valid   = wv;
        wr_data    = wd;
        read_addr  = ra;
        if (exp_run && !ls) begin
            e.data = exp_mem[ra];
            e.due  = cyc + LAT;
            sb.push_back(e);
        end
        if (ls) exp_run = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_beats(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            chk("wr_ready_load", 32'(wr_ready), 32'd1);
            chk("loaded_during", 32'(loaded), 32'd0);
            chk("phase_ena_during", 32'(phase_ena), 32'd0);
            exp_mem[i] = 8'(base + i);
            step(1'b0, 1'b1, 8'(base + i), 4'(i));
        end
        chk("wr_ready_done", 32'(wr_ready), 32'd0);
        chk("loaded_done", 32'(loaded), 32'd1);
        chk("phase_ena_done", 32'(phase_ena), 32'd1);
        exp_run = 1'b1;
    endtask

    task automatic read_up();
        for (int a = 0; a < 16; a++) step(1'b0, 1'b0, 8'h00, 4'(a));
    endtask

    initial begin
        rst        = 1'b0;
        load_start = 1'b0;
        wr_data    = 8'h00;
        wr_valid   = 1'b0;
        read_addr  = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_phase_ena", 32'(phase_ena), 32'd0);
        chk("rst_sample_out", 32'(sample_out), 32'd0);
        chk("rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00, 4'h0);
        chk("idle_wr_ready", 32'(wr_ready), 32'd0);

        // Basic load then read-back in order and at random addresses
        step(1'b1, 1'b0, 8'h00, 4'h0);
        load_beats(8'h10);
        read_up();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 4'($urandom_range(15)));

        // Reload from RUN with a stalled (toggling) load of 0xA0+i
        step(1'b1, 1'b0, 8'h00, 4'h3);
        chk("reload_phase_ena", 32'(phase_ena), 32'd0);
        chk("reload_loaded", 32'(loaded), 32'd0);
        chk("reload_wr_ready", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 32; i++) begin
            chk("stall_wr_ready", 32'(wr_ready), 32'd1);
            if (i % 2 == 1) exp_mem[i / 2] = 8'(8'hA0 + i / 2);
            step(1'b0, (i % 2 == 1), 8'(8'hA0 + i / 2), 4'h0);
            chk("stall_phase_ena", 32'(phase_ena), (i == 31) ? 32'd1 : 32'd0);
            chk("stall_loaded", 32'(loaded), (i == 31) ? 32'd1 : 32'd0);
        end
        exp_run = 1'b1;
        read_up();

        // Restart mid-load: 7 beats, then load_start with a beat that must be dropped
        step(1'b1, 1'b0, 8'h00, 4'h0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(8'h50 + i), 4'h0);
        step(1'b1, 1'b1, 8'hEE, 4'h0);
        chk("restart_wr_ready", 32'(wr_ready), 32'd1);
        chk("restart_loaded", 32'(loaded), 32'd0);
        load_beats(8'h30);
        for (int a = 15; a >= 0; a--) step(1'b0, 1'b0, 8'h00, 4'(a));

        // Asynchronous reset in the middle of RUN
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 4'(i));
        #2;
        rst = 1'b0;
        sb.delete();
        exp_run   = 1'b0;
        last_data = 8'h00;
        #1;
        chk("arst_wr_ready", 32'(wr_ready), 32'd0);
        chk("arst_phase_ena", 32'(phase_ena), 32'd0);
        chk("arst_sample_out", 32'(sample_out), 32'd0);
        chk("arst_sample_valid", 32'(sample_valid), 32'd0);
        chk("arst_loaded", 32'(loaded), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00, 4'(i));
            chk("post_rst_phase_ena", 32'(phase_ena), 32'd0);
        end
        step(1'b1, 1'b0, 8'h00, 4'h0);
        load_beats(8'h60);
        read_up();

        // Leave RUN and let the pipeline drain
        step(1'b1, 1'b0, 8'h00, 4'h0);
        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wave_ram_loader.md
# wave_ram_loader

Waveform sample store for the DDS chain, sitting directly downstream of the phase generator. It accepts a full table of 2**ADDR_WIDTH samples over a valid/ready load port. Once the table is complete it raises `phase_ena` to start the phase generator. It then returns one registered sample per clock for each `read_addr` the phase generator presents, with a matching `sample_valid` flag.

## Interface
- `DATA_WIDTH`, default 8: sample width in bits.
- `ADDR_WIDTH`, default 8: table address width; the table holds 2**ADDR_WIDTH entries.

Ports:
- `clk`  input  1  clock; all block logic on rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `load_start`  input  1  single-cycle request to (re)load the full table.
- `wr_data`  input  DATA_WIDTH  sample to write.
- `wr_valid`  input  1  `wr_data` is valid.
- `wr_ready`  output  1  block accepts a load beat this cycle.
- `read_addr`  input  ADDR_WIDTH  table address from the phase generator.
- `phase_ena`  output  1  enable to the phase generator.
- `sample_out`  output  DATA_WIDTH  table sample.
- `sample_valid`  output  1  `sample_out` carries a sample read during RUN.
- `loaded`  output  1  the table holds a complete, unbroken load.

## Operation
- FSM states: IDLE, LOAD, RUN. Reset enters IDLE.
- **IDLE**
  - `wr_ready`=0 and `phase_ena`=0.
  - `load_start`=1 moves to LOAD with `wr_ptr`=0 and `loaded`=0.
- **LOAD**
  - `wr_ready`=1.
  - A beat is accepted when `wr_valid` && `wr_ready` are both high. The accepted beat writes `mem[wr_ptr]` and increments `wr_ptr` (ADDR_WIDTH bits).
  - The beat accepted at `wr_ptr`=2**ADDR_WIDTH-1 ends the load. On that beat the FSM moves to RUN next cycle and sets `loaded`=1.
  - `load_start` in LOAD restarts the load: `wr_ptr`=0. Any beat presented in that cycle is discarded and not written.
  - `wr_valid`=0 stalls the load with no timeout.
- **RUN**
  - `phase_ena`=1 and `wr_ready`=0.
  - Every cycle the block reads `mem[read_addr]` into the output pipeline.
  - `load_start` moves to LOAD next cycle with `wr_ptr`=0 and `loaded`=0. `phase_ena` drops in the same edge.
- **Validity pipeline**
  - The valid stage input is (state==RUN && !`load_start`).
  - Reads issued in the cycle `load_start` is seen are flagged invalid.
- `sample_out` holds its last value while `sample_valid`=0.
- RAM contents are not reset. `rst` mid-load leaves a partial table with `loaded`=0.
- Reset values: `wr_ready`=0, `phase_ena`=0, `sample_out`=0, `sample_valid`=0, `loaded`=0, `wr_ptr`=0.

## Timing
- **Read latency:** 1 cycle by default (registered read). The address sampled at rising edge N appears on `sample_out` after edge N.
- **Phase generator interface:** the phase generator updates `read_addr` on the falling edge. The address is therefore stable a half-cycle before each rising edge here; no extra synchronisation.
- **LOAD to RUN:**
  - `phase_ena` goes high the cycle after the last load beat.
  - The first `sample_valid`=1 occurs one latency later.
- **Load throughput:** one beat per cycle. A full load takes exactly 2**ADDR_WIDTH accepted beats.
- **Write/read overlap:** none. Writes occur only in LOAD and reads are flagged valid only in RUN, so there is no read-during-write case.

## Configuration
- `WAVE_RAM_OUT_REG_EN`
  - Defined: adds a second output register stage. `sample_out` and `sample_valid` latency becomes 2 cycles, for timing closure to a downstream DAC.
  - Undefined: single registered read, latency 1.
- Control behaviour is identical in both cases. Only the pipeline depth changes.

## Test plan
All scenarios use ADDR_WIDTH=4 and DATA_WIDTH=8.
- **Reset:** assert `rst`=0 mid-RUN. All outputs go to 0 immediately and the FSM is in IDLE. After release, `phase_ena` stays 0 until a full load completes.
- **Basic load:** `load_start`, then 16 beats of `wr_data`=0x10+i with `wr_valid`=1 continuously. `wr_ready`=1 for exactly 16 cycles; `loaded`=1 and `phase_ena`=1 the cycle after beat 15.
- **Read-back:** in RUN, drive `read_addr` 0..15 on falling edges. `sample_out`=0x10..0x1F with `sample_valid`=1, each 1 cycle after sampling (2 with `WAVE_RAM_OUT_REG_EN`).
- **Stalled load:** `wr_valid` toggled 1/0 every cycle. Load completes after 32 cycles; table contents are correct.
- **Restart mid-load:** `load_start` after 7 beats, with `wr_valid`=1 that cycle. That beat is dropped and `wr_ptr` returns to 0; the next 16 beats form the table and `loaded`=1 only at the end.
- **Reload from RUN:** `load_start` in RUN. `phase_ena` and `loaded` go 0 the next cycle; `sample_valid` goes 0 after one latency; a new table of 0xA0+i reads back correctly.
